// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and helpers for the RGB LED PWM driver
package led_pkg;

    localparam int LED_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } led_state_e;

    typedef struct packed {
        logic r;
        logic g;
        logic be;
    } led_colour_t;

    typedef struct packed {
        led_colour_t            colour;
        logic [LED_CNT_W-1:0]   duty;
    } led_req_t;

    // True when at least one channel is enabled
    function automatic logic colour_any(input led_colour_t c);
        return c.r | c.g | c.be;
    endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// rtl/led_pwm_timebase.sv - prescaler and PWM period counter with hold-at-zero clear
module led_pwm_timebase #(
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] pwm_cnt,
    output logic             tick,
    output logic             boundary
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;

    // clr suppresses tick so a held timebase never reports a boundary
    assign tick     = !clr && (pre_cnt == PRE_MAX);
    assign boundary = tick && (pwm_cnt == '1);

    // Prescaler feeds the PWM counter; both held at zero while cleared
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_rgb_pwm_driver.sv
// rtl/led_rgb_pwm_driver.sv - RGB LED PWM driver with period-aligned colour updates (optional blink: LED_BLINK_EN)
module led_rgb_pwm_driver
    import led_pkg::*;
#(
    parameter int CNT_W         = 8,
    parameter int PRESCALE      = 4,
    parameter int BLINK_PERIODS = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             r_in,
    input  logic             g_in,
    input  logic             be_in,
    input  logic [CNT_W-1:0] duty,
    output logic             led_r,
    output logic             led_g,
    output logic             led_b,
`ifdef LED_BLINK_EN
    input  logic             blink_in,
`endif
    output logic             busy
);

    if (PRESCALE < 1 || BLINK_PERIODS < 1) begin : g_bad_params
        $error("led_rgb_pwm_driver: PRESCALE and BLINK_PERIODS must be >= 1");
    end

    led_state_e       state;
    led_colour_t      req_col;
    led_colour_t      active_col;
    led_colour_t      shadow_col;
    logic [CNT_W-1:0] active_duty;
    logic [CNT_W-1:0] shadow_duty;
    logic [CNT_W-1:0] pwm_cnt;
    logic             boundary;
    logic             tick_unused;
    logic             xfer;
    logic             duty_on;
    logic             blink_off;
    logic             drive;

    assign req_col  = '{r: r_in, g: g_in, be: be_in};
    assign in_ready = (state != PEND);
    assign busy     = (state != IDLE);
    assign xfer     = in_valid && in_ready;

    led_pwm_timebase #(
        .CNT_W    (CNT_W),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == IDLE),
        .pwm_cnt  (pwm_cnt),
        .tick     (tick_unused),
        .boundary (boundary)
    );

    // Request sequencing: IDLE loads active directly, RUN parks the request in shadow until the next boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            active_col  <= '0;
            active_duty <= '0;
            shadow_col  <= '0;
            shadow_duty <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        active_col  <= req_col;
                        active_duty <= duty;
                        state       <= colour_any(req_col) && (duty != '0) ? RUN : IDLE;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        shadow_col  <= req_col;
                        shadow_duty <= duty;
                        state       <= PEND;
                    end
                end
                PEND: begin
                    if (boundary) begin
                        active_col  <= shadow_col;
                        active_duty <= shadow_duty;
                        state       <= colour_any(shadow_col) && (shadow_duty != '0) ? RUN : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LED_BLINK_EN
    localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_PERIODS - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    // Count PWM periods; each wrap flips the blink phase, restarting from phase 0 whenever idle
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (boundary) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blink_off = blink_in && blink_phase;
`else
    assign blink_off = 1'b0;
`endif

    // All-ones duty is treated as fully on so the LED never drops for one tick per period
    assign duty_on = (active_duty == '1) || (pwm_cnt < active_duty);
    assign drive   = (state != IDLE) && duty_on && !blink_off;

    // Registered pin drive so the LED outputs are glitch-free
    always_ff @(posedge clk) begin
        if (rst) begin
            led_r <= 1'b0;
            led_g <= 1'b0;
            led_b <= 1'b0;
        end else begin
            led_r <= drive && active_col.r;
            led_g <= drive && active_col.g;
            led_b <= drive && active_col.be;
        end
    end

endmodule

// File: tb/tb_led_rgb_pwm_driver.sv
// tb/tb_led_rgb_pwm_driver.sv - scoreboard bench for led_rgb_pwm_driver (blink checks with LED_BLINK_EN)
module tb_led_rgb_pwm_driver;

    localparam int CNT_W         = 4;
    localparam int PRESCALE      = 2;
    localparam int BLINK_PERIODS = 2;

    localparam logic [4:0] M_LED = 5'b11100;
    localparam logic [4:0] M_RB  = 5'b00011;
    localparam logic [4:0] M_ALL = 5'b11111;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             r_in;
    logic             g_in;
    logic             be_in;
    logic [CNT_W-1:0] duty;
    logic             led_r;
    logic             led_g;
    logic             led_b;
    logic             busy;
`ifdef LED_BLINK_EN
    logic             blink_in;
`endif

    led_rgb_pwm_driver #(
        .CNT_W         (CNT_W),
        .PRESCALE      (PRESCALE),
        .BLINK_PERIODS (BLINK_PERIODS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .r_in     (r_in),
        .g_in     (g_in),
        .be_in    (be_in),
        .duty     (duty),
        .led_r    (led_r),
        .led_g    (led_g),
        .led_b    (led_b),
`ifdef LED_BLINK_EN
        .blink_in (blink_in),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // exp/mask bit order: {led_r, led_g, led_b, in_ready, busy}
    typedef struct {
        int         cyc;
        logic [4:0] exp;
        logic [4:0] mask;
        string      name;
    } chk_t;

    chk_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic expect_at(input int c, input logic [4:0] e, input logic [4:0] m, input string nm);
        chk_t x;
        x.cyc  = c;
        x.exp  = e;
        x.mask = m;
        x.name = nm;
        q.push_back(x);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic r, input logic g, input logic b, input logic [CNT_W-1:0] d);
        r_in     = r;
        g_in     = g;
        be_in    = b;
        duty     = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Monitor: every cycle, retire the expectations due now against the pins
    always @(negedge clk) begin
        logic [4:0] act;
        act = {led_r, led_g, led_b, in_ready, busy};
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                n_cmp++;
                if (q[i].cyc < cyc || ((act & q[i].mask) !== (q[i].exp & q[i].mask))) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d due=%0d got=%b need=%b mask=%b",
                             q[i].name, cyc, q[i].cyc, act, q[i].exp, q[i].mask);
                end
                q.delete(i);
            end
        end
    end

    int t2, t3, t4, t5, t6;
`ifdef LED_BLINK_EN
    int t8;
`endif

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        r_in     = 1'b1;
        g_in     = 1'b0;
        be_in    = 1'b0;
        duty     = 4'd8;
`ifdef LED_BLINK_EN
        blink_in = 1'b0;
`endif
        // 1: reset, with a transfer offered during reset
        step(2);
        n_cmp++;
        if (led_r !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_led_r got=%b", led_r);
        end
        n_cmp++;
        if (led_g !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_led_g got=%b", led_g);
        end
        n_cmp++;
        if (led_b !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_led_b got=%b", led_b);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_in_ready got=%b", in_ready);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy got=%b", busy);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        r_in     = 1'b0;
        expect_at(cyc,     5'b00010, M_ALL, "reset_state");
        expect_at(cyc + 2, 5'b00010, M_ALL, "xfer_in_reset_ignored");
        step(3);

        // 2: red at half duty from IDLE
        t2 = cyc;
        send(1'b1, 1'b0, 1'b0, 4'd8);
        expect_at(t2 + 1, 5'b00011, M_ALL, "busy_after_xfer");
        for (int k = 0; k < 64; k++)
            expect_at(t2 + 2 + k, {((k % 32) < 16), 4'b0000}, M_LED, "red_pwm");
        step(39);

        // 3: mid-period change to green full-on waits for the boundary
        t3 = cyc;
        send(1'b0, 1'b1, 1'b0, 4'd15);
        expect_at(t3 + 1,  5'b00001, M_RB, "pend_not_ready");
        expect_at(t2 + 64, 5'b00001, M_RB, "pend_until_boundary");
        expect_at(t2 + 65, 5'b00011, M_RB, "ready_after_boundary");
        for (int c = t2 + 66; c <= t2 + 97; c++)
            expect_at(c, 5'b01000, M_LED, "green_full_on");
        step(39);

        // 4: duty 0 request drops to IDLE at the boundary
        t4 = cyc;
        send(1'b1, 1'b1, 1'b1, 4'd0);
        expect_at(t4 + 1,  5'b00001, M_RB,  "pend_duty0");
        expect_at(t2 + 97, 5'b01010, M_ALL, "idle_after_duty0");
        expect_at(t2 + 98, 5'b00010, M_ALL, "leds_off_in_idle");
        expect_at(t2 + 99, 5'b00010, M_ALL, "leds_off_in_idle");
        step(19);

        // 5: reset while PEND discards the shadow
        t5 = cyc;
        send(1'b1, 1'b0, 1'b0, 4'd8);
        step(9);
        send(1'b0, 1'b1, 1'b0, 4'd15);
        expect_at(t5 + 11, 5'b00001, M_RB, "pend_before_rst");
        step(9);
        rst = 1'b1;
        expect_at(t5 + 21, 5'b00010, M_ALL, "rst_in_pend");
        step();
        rst = 1'b0;
        expect_at(t5 + 22, 5'b00010, M_ALL, "idle_after_rst");
        expect_at(t5 + 23, 5'b00010, M_ALL, "idle_after_rst");
        step(3);
        t6 = cyc;
        send(1'b0, 1'b0, 1'b1, 4'd4);
        for (int k = 0; k < 96; k++)
            expect_at(t6 + 2 + k, {2'b00, ((k % 32) < 8), 2'b00}, M_LED, "blue_quarter");
        // transfer on the boundary cycle must wait one whole period
        step(63);
        send(1'b1, 1'b0, 1'b0, 4'd15);
        expect_at(t6 + 65, 5'b00001, M_RB, "pend_on_boundary");
        for (int c = t6 + 98; c < t6 + 110; c++)
            expect_at(c, 5'b10000, M_LED, "red_after_full_period");
        step(47);

`ifdef LED_BLINK_EN
        // 6: blink gating on a full-on blue channel
        rst = 1'b1;
        step();
        rst = 1'b0;
        t8 = cyc;
        blink_in = 1'b1;
        send(1'b0, 1'b0, 1'b1, 4'd15);
        for (int k = 0; k < 192; k++)
            expect_at(t8 + 2 + k, {2'b00, ((k % 128) < 64), 2'b00}, M_LED, "blink_pattern");
        step(199);
        blink_in = 1'b0;
        for (int c = t8 + 201; c < t8 + 231; c++)
            expect_at(c, 5'b00100, M_LED, "blink_dropped");
        step(35);
`endif

        // drain the scoreboard with a bounded wait
        for (int w = 0; w < 300 && q.size() != 0; w++)
            step();
        while (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s never checked (due cyc %0d, now %0d)", q[0].name, q[0].cyc, cyc);
            q.delete(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
